// File: rtl/mmio_host.sv
// Memory-mapped test-host peripheral: halt/exit-code capture, signature bounds,
// a buffered console byte stream and a software-readable status word.
module mmio_host #(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] BASE       = 32'h2000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic            hit,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            halted,
  output logic [31:0]     halt_code,
  output logic [XLEN-1:0] sig_begin,
  output logic [XLEN-1:0] sig_end,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            overflow
);

  localparam int unsigned S  = XLEN / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [XLEN-1:0] BASE_X      = XLEN'(BASE);
  localparam logic [XLEN-1:0] ADDR_HALT   = BASE_X;
  localparam logic [XLEN-1:0] ADDR_SIGBEG = BASE_X + XLEN'(1 * S);
  localparam logic [XLEN-1:0] ADDR_SIGEND = BASE_X + XLEN'(2 * S);
  localparam logic [XLEN-1:0] ADDR_CONS   = BASE_X + XLEN'(3 * S);
  localparam logic [XLEN-1:0] ADDR_STATUS = BASE_X + XLEN'(4 * S);

  // Register state
  logic            halted_q,      halted_d;
  logic [31:0]     halt_code_q,   halt_code_d;
  logic [XLEN-1:0] sig_begin_q,   sig_begin_d;
  logic [XLEN-1:0] sig_end_q,     sig_end_d;
  logic            overflow_q,    overflow_d;
  logic [XLEN-1:0] rdata_q,       rdata_d;
  logic            rdata_valid_q, rdata_valid_d;

  // Console FIFO: one extra pointer bit separates full from empty.
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            fifo_empty;
  logic            fifo_full;

  // Address decode
  logic sel_halt, sel_sigbeg, sel_sigend, sel_cons, sel_status, in_window;
  logic wr_en, push_req, push, pop, drop;
  logic [XLEN-1:0] status_word;

  assign sel_halt   = (address == ADDR_HALT);
  assign sel_sigbeg = (address == ADDR_SIGBEG);
  assign sel_sigend = (address == ADDR_SIGEND);
  assign sel_cons   = (address == ADDR_CONS);
  assign sel_status = (address == ADDR_STATUS);
  assign in_window  = sel_halt | sel_sigbeg | sel_sigend | sel_cons | sel_status;

  assign hit = (load | store) & in_window;

  // Once halted, every register store is ignored; the FIFO keeps draining.
  assign wr_en = store & ~halted_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop      = ~fifo_empty & tx_ready;
  assign push_req = wr_en & sel_cons;
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & ~push;

  assign status_word = {{(XLEN-4){1'b0}}, overflow_q, fifo_full, fifo_empty, halted_q};

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    halted_d      = halted_q;
    halt_code_d   = halt_code_q;
    sig_begin_d   = sig_begin_q;
    sig_end_d     = sig_end_q;
    overflow_d    = overflow_q | drop;
    rdata_valid_d = load & in_window;
    rdata_d       = (load & sel_status) ? status_word : '0;
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop};

    if (wr_en && sel_halt && store_data[0]) begin
      halted_d    = 1'b1;
      halt_code_d = store_data[31:0];
    end
    if (wr_en && sel_sigbeg) begin
      sig_begin_d = store_data >> 1;
    end
    if (wr_en && sel_sigend) begin
      sig_end_d = (store_data >> 1) - XLEN'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      halted_q      <= 1'b0;
      halt_code_q   <= '0;
      sig_begin_q   <= '0;
      sig_end_q     <= '0;
      overflow_q    <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      halted_q      <= halted_d;
      halt_code_q   <= halt_code_d;
      sig_begin_q   <= sig_begin_d;
      sig_end_q     <= sig_end_d;
      overflow_q    <= overflow_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: the byte storage has no reset; emptiness is defined by the pointers,
  // so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= store_data[7:0];
    end
  end

  assign halted      = halted_q;
  assign halt_code   = halt_code_q;
  assign sig_begin   = sig_begin_q;
  assign sig_end     = sig_end_q;
  assign overflow    = overflow_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign tx_valid    = ~fifo_empty;
  assign tx_data     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_mmio_host.sv
// Self-checking bench for mmio_host: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mmio_host;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        load, store, tx_ready;
  logic [31:0] address, store_data;
  logic        hit, rdata_valid, halted, tx_valid, overflow;
  logic [31:0] rdata, halt_code, sig_begin, sig_end;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_errors = 0;

  mmio_host #(.XLEN(32), .BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .store      (store),
    .address    (address),
    .store_data (store_data),
    .hit        (hit),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .halted     (halted),
    .halt_code  (halt_code),
    .sig_begin  (sig_begin),
    .sig_end    (sig_end),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register index 0..4 for an exact slot hit, -1 otherwise.
  function automatic int slot_of(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if (off >= 32'd20 || off % 4 != 0) return -1;
    return int'(off / 4);
  endfunction

  // Reference model
  bit          m_halted = 0, m_ovf = 0, m_rdv = 0;
  logic [31:0] m_code = 0, m_sb = 0, m_se = 0, m_rdata = 0;
  byte unsigned m_q[$];

  always @(posedge clock) begin : model
    int          sl;
    bit          do_pop;
    logic [31:0] st;
    sl = slot_of(address);
    if (!reset) begin
      m_halted = 0; m_ovf = 0; m_rdv = 0;
      m_code = 0; m_sb = 0; m_se = 0; m_rdata = 0;
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() != 0) && tx_ready;
      st      = {28'd0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, m_halted};
      m_rdv   = load && (sl >= 0);
      m_rdata = (load && sl == 4) ? st : 32'd0;
      if (do_pop) void'(m_q.pop_front());
      if (store && sl >= 0 && !m_halted) begin
        case (sl)
          0: if (store_data[0]) begin m_halted = 1; m_code = store_data; end
          1: m_sb = store_data / 2;
          2: m_se = store_data / 2 - 32'd1;
          3: if (m_q.size() < DEPTH) m_q.push_back(store_data[7:0]); else m_ovf = 1;
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison, sampled just after the falling edge.
  initial begin : compare
    forever begin
      @(negedge clock);
      #1;
      check("hit", hit, (load || store) && slot_of(address) >= 0);
      check("halted", halted, m_halted);
      check("halt_code", halt_code, m_code);
      check("sig_begin", sig_begin, m_sb);
      check("sig_end", sig_end, m_se);
      check("overflow", overflow, m_ovf);
      check("rdata_valid", rdata_valid, m_rdv);
      if (m_rdv) check("rdata", rdata, m_rdata);
      check("tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
    end
  end

  task automatic drive(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d);
    load = l; store = s; address = a; store_data = d;
    @(negedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    drive(0, 1, BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off);
    drive(1, 0, BASE + off, 32'd0);
  endtask

  initial begin : stimulus
    reset = 0; load = 0; store = 0; address = 0; store_data = 0; tx_ready = 0;
    @(negedge clock);
    #2;
    idle(2);
    reset = 1;
    idle(2);

    // Reset state
    check("rst_halted", halted, 1'b0);
    check("rst_sig_begin", sig_begin, 32'h0);
    check("rst_sig_end", sig_end, 32'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);

    // Signature bounds, including the wrap of the inclusive end index
    wr(4, 32'h8000_1000);
    wr(8, 32'h8000_1100);
    check("sig_begin_val", sig_begin, 32'h4000_0800);
    check("sig_end_val", sig_end, 32'h4000_087F);
    wr(8, 32'h0);
    check("sig_end_wrap0", sig_end, 32'hFFFF_FFFF);
    wr(8, 32'h1);
    check("sig_end_wrap1", sig_end, 32'hFFFF_FFFF);
    wr(8, 32'h2);
    check("sig_end_two", sig_end, 32'h0);

    // Console: no bypass, then drain on consecutive cycles
    check("cons_pre_empty", tx_valid, 1'b0);
    wr(12, 32'h48);
    check("cons_valid_after_push", tx_valid, 1'b1);
    check("cons_head_H", tx_data, 8'h48);
    wr(12, 32'h69);
    check("cons_head_stable", tx_data, 8'h48);
    tx_ready = 1;
    idle(1);
    check("cons_head_i", tx_data, 8'h69);
    idle(1);
    check("cons_drained", tx_valid, 1'b0);
    tx_ready = 0;

    // Fill to depth, status read with simultaneous store, then overflow
    for (int i = 0; i < DEPTH; i++) wr(12, 32'h30 + 32'(i));
    drive(1, 1, BASE + 32'd16, 32'hFFFF_FFFF);
    check("status_full", rdata, 32'h4);
    check("status_full_valid", rdata_valid, 1'b1);
    check("no_overflow_yet", overflow, 1'b0);
    wr(12, 32'h38);
    check("overflow_set", overflow, 1'b1);
    check("head_after_drop", tx_data, 8'h30);
    rd(16);
    check("status_ovf_full", rdata, 32'hC);
    tx_ready = 1;
    wr(12, 32'h39);
    tx_ready = 0;
    rd(16);
    check("status_still_full", rdata, 32'hC);
    check("head_after_swap", tx_data, 8'h31);
    tx_ready = 1;
    idle(DEPTH - 1);
    check("last_byte", tx_data, 8'h39);
    idle(1);
    check("full_drain_empty", tx_valid, 1'b0);
    tx_ready = 0;

    // Halt: bit0 clear ignored, then halt freezes stores but FIFO drains
    wr(0, 32'h0);
    check("halt_bit0_clear", halted, 1'b0);
    wr(12, 32'h41);
    wr(12, 32'h42);
    wr(0, 32'h2B);
    check("halted_set", halted, 1'b1);
    check("halt_code_val", halt_code, 32'h2B);
    wr(12, 32'h43);
    wr(4, 32'h100);
    wr(0, 32'h55);
    check("halt_code_frozen", halt_code, 32'h2B);
    check("sig_begin_frozen", sig_begin, 32'h4000_0800);
    tx_ready = 1;
    idle(1);
    check("halted_drain_B", tx_data, 8'h42);
    idle(1);
    check("halted_drain_empty", tx_valid, 1'b0);
    rd(16);
    check("status_halted", rdata, 32'hB);
    tx_ready = 0;

    // Reset clears halt; out-of-window and misaligned accesses do nothing
    reset = 0;
    idle(1);
    reset = 1;
    check("rst2_halted", halted, 1'b0);
    load = 0; store = 1; address = BASE + 32'd2; store_data = 32'h1;
    #1;
    check("miss_base2_hit", hit, 1'b0);
    @(negedge clock); #2;
    load = 1; store = 0; address = BASE + 32'd20; store_data = 32'h0;
    #1;
    check("miss_base20_hit", hit, 1'b0);
    @(negedge clock); #2;
    check("miss_no_rdata_valid", rdata_valid, 1'b0);
    wr(6, 32'h1234);
    wr(32'hFFFF_FFFC, 32'h1);
    check("miss_halted", halted, 1'b0);
    check("miss_sig_begin", sig_begin, 32'h0);
    load = 0; store = 1; address = BASE + 32'd16; store_data = 32'h0;
    #1;
    check("status_slot_hit", hit, 1'b1);
    @(negedge clock); #2;

    // Mid-stream reset with bytes queued and a load pending
    wr(12, 32'h61);
    wr(12, 32'h62);
    wr(12, 32'h63);
    wr(0, 32'h1);
    check("pre_reset_halted", halted, 1'b1);
    check("pre_reset_valid", tx_valid, 1'b1);
    reset = 0;
    drive(1, 0, BASE + 32'd16, 32'd0);
    check("flush_tx_valid", tx_valid, 1'b0);
    check("flush_halted", halted, 1'b0);
    check("flush_rdata_valid", rdata_valid, 1'b0);
    reset = 1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
